stack_panel_renderer: RTL and testbench



---
 rtl/sidebar_pkg.sv | 39 +++
 rtl/stack_gap_finder.sv | 29 ++
 rtl/stack_panel_renderer.sv | 131 +++++++++++++
 tb/tb_stack_panel_renderer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sidebar_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sidebar_pkg
//  Description : Shared constants, FSM encoding and per-layer pixel rule for
//                the stack panel renderer.
//  Revision    : 1.0 - initial release
// ============================================================================
package sidebar_pkg;

  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] WHITE  = 3'b111;
  localparam logic [2:0] CHERRY = 3'b111;
  localparam logic [2:0] EMPTY  = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECIPE = 2'd1,
    S_CAUGHT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Colour of one pixel inside a layer row. A cherry is a two-pixel red dot
  // centred in the panel; a normal layer leaves a one-pixel black margin.
  function automatic logic [2:0] layer_pixel(input logic [2:0] c,
                                             input int col,
                                             input int layer_w);
    logic [2:0] px;
    px = BLACK;
    if (c == CHERRY) begin
      if (col == layer_w / 2 - 1 || col == layer_w / 2) px = RED;
    end else if (c != EMPTY) begin
      if (col >= 1 && col <= layer_w - 2) px = c;
    end
    return px;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stack_gap_finder.sv
`default_nettype none
// ============================================================================
//  Module      : stack_gap_finder
//  Description : Combinational search for the lowest empty layer in a stack.
//                Reports NUM_LAYERS when every layer is occupied.
//  Ports       : i_stack - packed 3-bit layer colours, [2:0] is the bottom
//                o_gap   - index of the lowest empty layer
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_gap_finder
  import sidebar_pkg::*;
#(
  parameter int NUM_LAYERS = 6,
  parameter int IDX_W      = $clog2(NUM_LAYERS + 1)
) (
  input  logic [3*NUM_LAYERS-1:0] i_stack,
  output logic [IDX_W-1:0]        o_gap
);

  // Scan top-down so the lowest empty layer is the last one written.
  always_comb begin
    o_gap = IDX_W'(NUM_LAYERS);
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (i_stack[3*i +: 3] == EMPTY) o_gap = IDX_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/stack_panel_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : stack_panel_renderer
//  Description : Snapshots the recipe and caught stacks on start, then streams
//                the recipe panel followed by the caught panel to the VGA pixel
//                writer over a plot/ready handshake.
//  Ports       : clock, resetn       - clock, async active-low reset
//                start, erase_done   - redraw request, release from DONE
//                recipe, cake_caught - packed 3-bit layer colours
//                ready               - writer accepts the current pixel
//                plot, x, y, colour  - pixel stream
//                draw_done, match    - both panels drawn, stacks equal
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_panel_renderer
  import sidebar_pkg::*;
#(
  parameter int NUM_LAYERS = 6,
  parameter int LAYER_W    = 6,
  parameter int LAYER_H    = 2,
  parameter int X_ORIGIN   = 2,
  parameter int Y_RECIPE   = 10,
  parameter int Y_CAUGHT   = 40
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    start,
  input  logic                    erase_done,
  input  logic [3*NUM_LAYERS-1:0] recipe,
  input  logic [3*NUM_LAYERS-1:0] cake_caught,
  input  logic                    ready,
  output logic                    plot,
  output logic [7:0]              x,
  output logic [6:0]              y,
  output logic [2:0]              colour,
  output logic                    draw_done,
  output logic                    match
);

  localparam int PLATE_ROW = NUM_LAYERS * LAYER_H;
  localparam int COL_W     = (LAYER_W > 1) ? $clog2(LAYER_W) : 1;
  localparam int ROW_W     = $clog2(PLATE_ROW + 1);
  localparam int IDX_W     = $clog2(NUM_LAYERS + 1);

  state_t                  r_state, w_next;
  logic [COL_W-1:0]        r_col;
  logic [ROW_W-1:0]        r_row;
  logic [3*NUM_LAYERS-1:0] r_recipe, r_caught;
  logic                    r_match;

  logic [IDX_W-1:0]        w_gap, w_lidx;
  logic [3*NUM_LAYERS-1:0] w_stack;
  logic [2:0]              w_c, w_pix;
  logic                    w_accept, w_last_col, w_last_row;

  stack_gap_finder #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W)
  ) u_gap (
    .i_stack (r_caught),
    .o_gap   (w_gap)
  );

  assign plot       = (r_state == S_RECIPE) || (r_state == S_CAUGHT);
  assign w_accept   = plot && ready;
  assign w_last_col = (r_col == COL_W'(LAYER_W - 1));
  assign w_last_row = (r_row == ROW_W'(PLATE_ROW));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_RECIPE;
      S_RECIPE: if (w_accept && w_last_col && w_last_row) w_next = S_CAUGHT;
      S_CAUGHT: if (w_accept && w_last_col && w_last_row) w_next = S_DONE;
      S_DONE:   if (erase_done) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_col    <= '0;
      r_row    <= '0;
      r_recipe <= '0;
      r_caught <= '0;
      r_match  <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_recipe <= recipe;
      r_caught <= cake_caught;
      r_match  <= (recipe == cake_caught);
      r_col    <= '0;
      r_row    <= '0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col <= '0;
        // Wrapping the row here also clears it for the second panel.
        r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Pixel colour. w_lidx is meaningless on the plate row, which overrides it.
  always_comb begin
    w_stack = (r_state == S_CAUGHT) ? r_caught : r_recipe;
    w_lidx  = IDX_W'(NUM_LAYERS - 1 - int'(r_row) / LAYER_H);
    w_c     = EMPTY;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (w_lidx == IDX_W'(i)) w_c = w_stack[3*i +: 3];
    end
    w_pix = layer_pixel(w_c, int'(r_col), LAYER_W);
    // Everything at or above the first hole in the caught stack is stale.
    if (r_state == S_CAUGHT && w_lidx >= w_gap) w_pix = BLACK;
    if (w_last_row) w_pix = WHITE;
    if (!plot)      w_pix = BLACK;
  end

  assign colour    = w_pix;
  assign x         = plot ? 8'(X_ORIGIN) + 8'(r_col) : 8'd0;
  assign y         = plot ? 7'(((r_state == S_CAUGHT) ? Y_CAUGHT : Y_RECIPE) + int'(r_row)) : 7'd0;
  assign draw_done = (r_state == S_DONE);
  assign match     = r_match;

endmodule
`default_nettype wire

// File: tb/tb_stack_panel_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stack_panel_renderer
//  Description : Scoreboard bench. Each redraw pushes the full expected pixel
//                stream of both panels into a queue; a monitor pops one entry
//                per accepted pixel. Two instances: default geometry and a
//                4-layer, 8-wide, 3-high geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_panel_renderer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: defaults ----------------
  logic        rstn_a = 1'b0, start_a = 1'b0, erase_a = 1'b0, ready_a = 1'b1;
  logic [17:0] rec_a = '0, cau_a = '0;
  logic        plot_a, done_a, match_a;
  logic [7:0]  x_a;
  logic [6:0]  y_a;
  logic [2:0]  col_a;

  stack_panel_renderer dut_a (
    .clock(clk), .resetn(rstn_a), .start(start_a), .erase_done(erase_a),
    .recipe(rec_a), .cake_caught(cau_a), .ready(ready_a),
    .plot(plot_a), .x(x_a), .y(y_a), .colour(col_a),
    .draw_done(done_a), .match(match_a));

  // ---------------- instance B: alternate geometry ----------------
  logic        rstn_b = 1'b0, start_b = 1'b0, erase_b = 1'b0, ready_b = 1'b1;
  logic [11:0] rec_b = '0, cau_b = '0;
  logic        plot_b, done_b, match_b;
  logic [7:0]  x_b;
  logic [6:0]  y_b;
  logic [2:0]  col_b;

  stack_panel_renderer #(.NUM_LAYERS(4), .LAYER_W(8), .LAYER_H(3)) dut_b (
    .clock(clk), .resetn(rstn_b), .start(start_b), .erase_done(erase_b),
    .recipe(rec_b), .cake_caught(cau_b), .ready(ready_b),
    .plot(plot_b), .x(x_b), .y(y_b), .colour(col_b),
    .draw_done(done_b), .match(match_b));

  int errors = 0;
  int checks = 0;
  logic [17:0] qa[$];
  logic [17:0] qb[$];
  int rmode_a = 0, rmode_b = 0;   // 0: ready high, 1: 1,0,0,1 pattern, 2: random
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference colour of pixel (row r, column k) for a panel, from the drawing
  // rules: plate row white; otherwise look up the layer under this row.
  function automatic logic [2:0] exp_pix(input int n, input int w, input int h,
                                         input logic [23:0] stk, input bit caught,
                                         input int r, input int k);
    int L, gap;
    logic [2:0] c;
    if (r == n * h) return 3'b111;
    L = n - 1 - r / h;
    gap = n;
    for (int j = n - 1; j >= 0; j--) if (stk[3*j +: 3] == 3'b000) gap = j;
    if (caught && L >= gap) return 3'b000;
    c = stk[3*L +: 3];
    if (c == 3'b111) return (k == w/2 - 1 || k == w/2) ? 3'b100 : 3'b000;
    if (c == 3'b000) return 3'b000;
    return (k >= 1 && k <= w - 2) ? c : 3'b000;
  endfunction

  task automatic push_draw(input bit to_b, input logic [23:0] rec, input logic [23:0] cau);
    int n, w, h;
    logic [17:0] e;
    n = to_b ? 4 : 6;
    w = to_b ? 8 : 6;
    h = to_b ? 3 : 2;
    for (int p = 0; p < 2; p++)
      for (int r = 0; r <= n * h; r++)
        for (int k = 0; k < w; k++) begin
          e = {8'(2 + k), 7'((p == 0 ? 10 : 40) + r),
               exp_pix(n, w, h, (p == 0) ? rec : cau, p == 1, r, k)};
          if (to_b) qb.push_back(e);
          else      qa.push_back(e);
        end
  endtask

  // Ready drivers
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk); #1;
      case (rmode_a)
        0:       ready_a = 1'b1;
        1:       ready_a = pat[ph % 4];
        default: ready_a = 1'($urandom_range(0, 1));
      endcase
      ready_b = (rmode_b == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      ph++;
    end
  end

  // Monitor A
  initial begin
    logic [17:0] held, e;
    bit stall;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (!rstn_a) begin stall = 1'b0; continue; end
      if (stall)
        chk(plot_a && {x_a, y_a, col_a} == held, "hold_a",
            32'({plot_a, x_a, y_a, col_a}), 32'({1'b1, held}));
      if (plot_a && ready_a) begin
        if (qa.size() == 0) chk(1'b0, "extra_pixel_a", 32'({x_a, y_a, col_a}), 32'(0));
        else begin
          e = qa.pop_front();
          chk({x_a, y_a, col_a} == e, "pixel_a", 32'({x_a, y_a, col_a}), 32'(e));
        end
      end
      stall = plot_a && !ready_a;
      held  = {x_a, y_a, col_a};
    end
  end

  // Monitor B
  initial begin
    logic [17:0] held, e;
    bit stall;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (!rstn_b) begin stall = 1'b0; continue; end
      if (stall)
        chk(plot_b && {x_b, y_b, col_b} == held, "hold_b",
            32'({plot_b, x_b, y_b, col_b}), 32'({1'b1, held}));
      if (plot_b && ready_b) begin
        if (qb.size() == 0) chk(1'b0, "extra_pixel_b", 32'({x_b, y_b, col_b}), 32'(0));
        else begin
          e = qb.pop_front();
          chk({x_b, y_b, col_b} == e, "pixel_b", 32'({x_b, y_b, col_b}), 32'(e));
        end
      end
      stall = plot_b && !ready_b;
      held  = {x_b, y_b, col_b};
    end
  end

  // One full redraw on instance A. poke: extra start pulses in RECIPE and DONE.
  task automatic run_a(input logic [17:0] rec, input logic [17:0] cau,
                       input int mode, input bit poke, input bit scramble);
    int n;
    rec_a = rec; cau_a = cau; rmode_a = mode;
    @(posedge clk); #1;
    push_draw(1'b0, 24'(rec), 24'(cau));
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk(match_a == (rec == cau), "match", 32'(match_a), 32'(rec == cau));
    if (scramble) begin rec_a = 18'($urandom); cau_a = 18'($urandom); end
    n = 0;
    if (poke) begin
      repeat (10) begin @(posedge clk); #1; n++; end
      start_a = 1'b1;
      @(posedge clk); #1; n++;
      start_a = 1'b0;
    end
    while (!done_a && n < 5000) begin @(posedge clk); #1; n++; end
    chk(done_a, "done_timeout", 32'(done_a), 32'(1));
    if (mode == 0 && !poke) chk(n == 156, "latency", 32'(n), 32'(156));
    chk(qa.size() == 0, "drain_a", 32'(qa.size()), 32'(0));
    chk(!plot_a && match_a == (rec == cau), "done_state",
        32'({plot_a, match_a}), 32'({1'b0, rec == cau}));
    if (poke) begin
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk(done_a && !plot_a, "start_in_done", 32'({done_a, plot_a}), 32'(2'b10));
    end
    erase_a = 1'b1; start_a = poke;
    @(posedge clk); #1;
    erase_a = 1'b0; start_a = 1'b0;
    chk(!done_a && !plot_a, "erase_to_idle", 32'({done_a, plot_a}), 32'(0));
    @(posedge clk); #1;
    chk(!plot_a, "no_capture", 32'(plot_a), 32'(0));
  endtask

  task automatic run_b(input logic [11:0] rec, input logic [11:0] cau, input int mode);
    int n;
    rec_b = rec; cau_b = cau; rmode_b = mode;
    @(posedge clk); #1;
    push_draw(1'b1, 24'(rec), 24'(cau));
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 5000) begin @(posedge clk); #1; n++; end
    chk(done_b, "done_timeout_b", 32'(done_b), 32'(1));
    if (mode == 0) chk(n == 208, "latency_b", 32'(n), 32'(208));
    chk(qb.size() == 0 && match_b == (rec == cau), "drain_b",
        32'({qb.size(), match_b}), 32'({32'd0, rec == cau}));
    erase_b = 1'b1;
    @(posedge clk); #1;
    erase_b = 1'b0;
  endtask

  function automatic logic [17:0] rand_stack();
    logic [17:0] s;
    for (int i = 0; i < 6; i++)
      s[3*i +: 3] = ($urandom_range(0, 4) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
    return s;
  endfunction

  initial begin
    int n;
    logic [17:0] r, c;
    #23;
    chk({plot_a, x_a, y_a, col_a, done_a, match_a} == '0, "reset_state",
        32'({plot_a, x_a, y_a, col_a, done_a, match_a}), 32'(0));
    @(posedge clk); #1;
    rstn_a = 1'b1; rstn_b = 1'b1;
    @(posedge clk); #1;
    chk(!plot_a && !done_a, "idle_after_reset", 32'({plot_a, done_a}), 32'(0));

    run_a(18'o754321, 18'o754321, 0, 1'b0, 1'b0);   // full stacks, match
    run_a(18'o754321, 18'o000321, 0, 1'b0, 1'b0);   // empty top layers
    run_a(18'o754321, 18'o700301, 1, 1'b0, 1'b0);   // hole at layer 1
    run_a(18'o754321, 18'o754321, 1, 1'b0, 1'b1);   // back-pressure, inputs change
    run_a(18'o123457, 18'o765432, 2, 1'b1, 1'b1);   // ignored start pulses

    for (int t = 0; t < 4; t++) begin
      r = rand_stack();
      c = ($urandom_range(0, 1) == 0) ? r : rand_stack();
      run_a(r, c, 2, 1'b0, 1'b1);
    end

    // Asynchronous reset in the middle of the caught panel
    rec_a = 18'o754321; cau_a = 18'o754321; rmode_a = 2;
    @(posedge clk); #1;
    push_draw(1'b0, 24'(rec_a), 24'(cau_a));
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    n = 0;
    while (!(plot_a && y_a >= 7'd44) && n < 2000) begin @(posedge clk); #1; n++; end
    chk(plot_a && y_a >= 7'd44, "reach_caught", 32'({plot_a, y_a}), 32'({1'b1, 7'd44}));
    #2 rstn_a = 1'b0;
    #1;
    chk(!plot_a && !done_a && !match_a, "async_reset",
        32'({plot_a, done_a, match_a}), 32'(0));
    qa.delete();
    @(posedge clk); #1;
    rstn_a = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk(!plot_a && !done_a, "idle_after_abort", 32'({plot_a, done_a}), 32'(0));
    run_a(18'o700021, 18'o700021, 0, 1'b0, 1'b0);

    // Alternate geometry: 4 layers, 8 wide, 3 high
    run_b(12'o7321, 12'o7321, 0);
    run_b(12'o7654, 12'o7054, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
